coe_out_seq: RTL and testbench
==============================

// Module: coe_out_seq
// PURPOSE
//  Frame sequencer for the coefficient output buffer (1024 x 160b distributed RAM, 1-cycle registered read).
//  Accepts one frame of coefficient words from the matrix engine on a valid/ready stream and writes it to RAM.
//  Then drains the frame in write order on a valid/ready output stream, at 1 word/cycle under no backpressure.
//  Sits between the matrix datapath and the downstream packer/DMA; owns the only RAM instance.
// PARAMETERS
//  DWIDTH  160   word width, bits
//  AWIDTH  10    RAM address width
//  WORDS   1024  RAM depth (= 2**AWIDTH)
// PORTS
//  clk        in   1         single clock, all logic on posedge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         1-cycle pulse: begin a frame (sampled in IDLE only)
//  frame_len  in   AWIDTH+1  words in frame, legal 1..WORDS, sampled with start
//  busy       out  1         high in FILL or DRAIN
//  err        out  1         1-cycle pulse: illegal start
//  in_valid   in   1         write-stream valid
//  in_ready   out  1         write-stream ready
//  in_data    in   DWIDTH    write-stream word
//  out_valid  out  1         read-stream valid
//  out_ready  in   1         read-stream ready
//  out_data   out  DWIDTH    read-stream word; stable while out_valid & !out_ready
//  done       out  1         1-cycle pulse on the cycle the last word handshakes out
// BEHAVIOUR
//  Reset: state=IDLE; busy, err, in_ready, out_valid and done=0; out_data=0; counters and skid buffer cleared.
//   RAM contents are not cleared. Reset mid-frame discards the frame immediately.
//  States: IDLE -> FILL -> DRAIN -> IDLE.
//  IDLE: start with 1<=frame_len<=WORDS latches len_q and goes to FILL next cycle.
//   start with frame_len 0 or >WORDS: err pulses next cycle; state stays IDLE.
//  start while busy: ignored; err pulses next cycle; the frame continues unaffected.
//  FILL: in_ready=1. Each in_valid&in_ready writes in_data to waddr=wcnt in the same cycle (wen); wcnt++.
//   The write of word len_q-1 moves state to DRAIN on the same edge; in_ready=0 from the next cycle.
//  DRAIN: rcnt is the next read address. Read issue is allowed when rcnt<len_q and (occ+inflight-pop)<2.
//   occ = skid entries (0..2); inflight = read issued last cycle (0/1); pop = out_valid&out_ready.
//   Issued read: raddr=rcnt, rcnt++, inflight=1. The next cycle rdat is captured into the skid tail.
//   out_valid = (occ!=0); out_data = skid head.
//   First out_valid: 2 cycles after DRAIN entry. Sustained 1 word/cycle while out_ready=1.
//   Backpressure: the issue rule keeps the skid buffer from overflowing; no word is lost or duplicated.
//  Last output handshake (ocnt==len_q-1): done=1 that cycle (combinational on the handshake).
//   The state returns to IDLE on the same edge; start is accepted from the next cycle.
//  len_q==1: one write, one read, done. len_q==WORDS: addresses 0..WORDS-1, no wrap within a frame.
//  Counters are AWIDTH+1 bits so that len_q==WORDS compares without aliasing.
//  in_valid outside FILL is ignored (in_ready=0). out_ready outside DRAIN has no effect.
// STRUCTURE
//  Shared package (coe_pkg): DWIDTH/AWIDTH/WORDS constants; state encoding ST_IDLE/ST_FILL/ST_DRAIN.
//  One sub-module: coe_out_ram (RAM instance, wen/waddr/raddr/wdat/rdat). Sequencer, counters and skid stay local.
// TESTING
//  1. frame_len=4, in_valid always, out_ready always.
//     -> 4 writes in 4 cycles; out_valid 2 cycles after DRAIN; data order w0..w3; done with w3.
//  2. frame_len=1024, random in_valid and out_ready (50%) -> all 1024 words in order; one done pulse; no extra out_valid.
//  3. frame_len=8, out_ready low 5 cycles mid-drain -> out_data held stable; no loss or duplicate; occ never >2.
//  4. start with frame_len=0, then 1025, then a start during FILL -> err pulses x3; no state change; frame intact.
//  5. rst asserted mid-DRAIN (frame_len=16, after 5 outputs), then frame_len=2
//     -> outputs clear asynchronously; new frame returns its 2 new words.
//  6. frame_len=1 back-to-back with start on the cycle after done -> accepted; 2 correct frames, 2 done pulses.

Source files
------------

// File: rtl/coe_pkg.sv
// Shared constants, state encoding and helpers for the coefficient output buffer sequencer.
package coe_pkg;

  localparam int DWIDTH = 160;
  localparam int AWIDTH = 10;
  localparam int WORDS  = 1 << AWIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One bit wider than an address so a full 1024-word frame compares without aliasing.
  typedef logic [AWIDTH:0]   cnt_t;
  typedef logic [DWIDTH-1:0] word_t;

  function automatic logic len_legal(input cnt_t len);
    return (len != '0) && (len <= cnt_t'(WORDS));
  endfunction

endpackage

// File: rtl/coe_out_ram.sv
// Coefficient buffer storage: single write port, registered read port with 1-cycle latency.
module coe_out_ram
  import coe_pkg::*;
(
  input  logic              clk,
  input  logic              wen,
  input  logic [AWIDTH-1:0] waddr,
  input  word_t             wdat,
  input  logic [AWIDTH-1:0] raddr,
  output word_t             rdat
);

  word_t mem_q [WORDS];

  // NOTE: the array and its read register carry no reset, so they map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdat;
    end
    rdat <= mem_q[raddr];
  end

endmodule

// File: rtl/coe_out_seq.sv
// Frame sequencer: fills the coefficient RAM from the input stream, then drains it in order
// through a two-entry skid buffer that hides the RAM read latency under backpressure.
module coe_out_seq
  import coe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AWIDTH:0] frame_len,
  output logic          busy,
  output logic          err,
  input  logic          in_valid,
  output logic          in_ready,
  input  word_t         in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_data,
  output logic          done
);

  logic [1:0] state_q, state_d;
  cnt_t       len_q, len_d;
  cnt_t       wcnt_q, wcnt_d;
  cnt_t       rcnt_q, rcnt_d;
  cnt_t       ocnt_q, ocnt_d;
  logic       err_q, err_d;
  logic       inflight_q;
  logic [1:0] occ_q, occ_d;
  logic [1:0] occ_pop;
  word_t      skid_q [2];
  word_t      skid_d [2];

  cnt_t       len_m1;
  logic       wen;
  logic       last_wr;
  logic       pop;
  logic       issue;
  logic [2:0] level;
  word_t      rdat;

  assign len_m1    = len_q - cnt_t'(1);
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_FILL);
  assign wen       = in_valid & in_ready;
  assign last_wr   = wen && (wcnt_q == len_m1);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = skid_q[0];
  assign pop       = out_valid & out_ready;
  assign done      = pop && (ocnt_q == len_m1);
  assign err       = err_q;

  // Skid occupancy after this cycle's pop plus the read landing next cycle must stay within 2.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ST_DRAIN) && (rcnt_q < len_q) && (level < 3'd2);

  coe_out_ram u_ram (
    .clk   (clk),
    .wen   (wen),
    .waddr (wcnt_q[AWIDTH-1:0]),
    .wdat  (in_data),
    .raddr (rcnt_q[AWIDTH-1:0]),
    .rdat  (rdat)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ocnt_d  = ocnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_legal(frame_len)) begin
            state_d = ST_FILL;
            len_d   = frame_len;
            wcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        err_d = start;
        if (wen) begin
          wcnt_d = wcnt_q + cnt_t'(1);
        end
        if (last_wr) begin
          state_d = ST_DRAIN;
          rcnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        err_d = start;
        if (issue) begin
          rcnt_d = rcnt_q + cnt_t'(1);
        end
        if (pop) begin
          ocnt_d = ocnt_q + cnt_t'(1);
        end
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    skid_d  = skid_q;
    occ_pop = occ_q - {1'b0, pop};
    if (pop) begin
      skid_d[0] = skid_q[1];
    end
    occ_d = occ_pop;
    if (inflight_q) begin
      skid_d[occ_pop[0]] = rdat;
      occ_d              = occ_pop + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      err_q      <= err_d;
      inflight_q <= issue;
      occ_q      <= occ_d;
      skid_q[0]  <= skid_d[0];
      skid_q[1]  <= skid_d[1];
    end
  end

endmodule

// File: tb/tb_coe_out_seq.sv
// Self-checking bench for coe_out_seq: a queue-based frame model checks every cycle,
// and directed scenarios pin latency, pulse counts and reset behaviour with literal values.
module tb_coe_out_seq;
  import coe_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AWIDTH:0] frame_len = '0;
  logic          busy, err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  word_t         in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  word_t         out_data;
  logic          done;

  always #5 clk = ~clk;

  coe_out_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Frame model: words accepted so far, words still to accept and still to emit.
  word_t exp_q[$];
  int    m_in_left  = 0;
  int    m_out_left = 0;
  int    m_wr_count = 0;
  logic  err_exp    = 1'b0;
  logic  stall_prev = 1'b0;
  logic  m_idle, m_legal, m_hs, m_done_exp;

  int cyc = 0, done_seen = 0, err_seen = 0, frame_outs = 0, last_frame_outs = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, first_ov_cyc = -1, done_cyc = 0;
  int in_prob = 0, out_prob = 0;

  // Input driver: random valid/ready at the requested percentages, fresh data every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    in_valid  = ($urandom_range(99) < in_prob);
    in_data   = rand_word();
    out_ready = ($urandom_range(99) < out_prob);
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_in_left  = 0;
      m_out_left = 0;
      err_exp    = 1'b0;
      stall_prev = 1'b0;
      frame_outs = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
    end else begin
      m_idle  = (m_in_left == 0) && (m_out_left == 0);
      m_legal = (int'(frame_len) >= 1) && (int'(frame_len) <= WORDS);
      check("busy", busy, !m_idle);
      check("in_ready", in_ready, m_in_left > 0);
      check("err", err, err_exp);
      if (err) err_seen++;
      err_exp = start && !(m_idle && m_legal);

      m_hs = out_valid && out_ready;
      if (stall_prev) check("hold_valid", out_valid, 1);
      check("out_valid_legal", out_valid && !(m_in_left == 0 && exp_q.size() > 0), 0);
      if (out_valid && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      m_done_exp = m_hs && (exp_q.size() > 0) && (m_out_left == 1);
      check("done", done, m_done_exp);
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (m_hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_out_left--;
        frame_outs++;
        if (m_out_left == 0) last_frame_outs = frame_outs;
      end
      stall_prev = out_valid && !out_ready;

      if (in_valid && m_in_left > 0) begin
        if (m_wr_count == 0) first_wr_cyc = cyc;
        exp_q.push_back(in_data);
        m_in_left--;
        m_wr_count++;
        if (m_in_left == 0) last_wr_cyc = cyc;
      end

      if (start && m_idle && m_legal) begin
        m_in_left    = int'(frame_len);
        m_out_left   = int'(frame_len);
        m_wr_count   = 0;
        frame_outs   = 0;
        first_ov_cyc = -1;
      end
    end
  end

  task automatic do_start(input int len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    frame_len = (AWIDTH+1)'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_seen;
    int k  = 0;
    while (done_seen == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, done_seen != d0, 1);
  endtask

  task automatic wait_outs(input string name, input int n, input int budget);
    int k = 0;
    while (frame_outs < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, frame_outs >= n, 1);
  endtask

  int d0, e0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_err", err, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // 1: four words, no backpressure.
    in_prob = 100; out_prob = 100;
    d0 = done_seen;
    do_start(4);
    wait_done("t1_timeout", 200);
    check("t1_words", last_frame_outs, 4);
    check("t1_fill_cycles", last_wr_cyc - first_wr_cyc, 3);
    check("t1_first_valid", first_ov_cyc - last_wr_cyc, 3);
    check("t1_done_cycle", done_cyc - last_wr_cyc, 6);
    repeat (3) @(posedge clk);
    check("t1_done_count", done_seen - d0, 1);

    // 2: full-depth frame with random valid and ready.
    in_prob = 50; out_prob = 50;
    d0 = done_seen;
    do_start(1024);
    wait_done("t2_timeout", 12000);
    check("t2_words", last_frame_outs, 1024);
    repeat (5) @(posedge clk);
    check("t2_done_count", done_seen - d0, 1);
    check("t2_idle_after", busy, 0);

    // 3: ready held low for five cycles in the middle of the drain.
    in_prob = 100; out_prob = 100;
    do_start(8);
    wait_outs("t3_reach", 3, 200);
    out_prob = 0;
    repeat (5) @(posedge clk);
    #2;
    check("t3_stall_valid", out_valid, 1);
    out_prob = 100;
    wait_done("t3_timeout", 200);
    check("t3_words", last_frame_outs, 8);

    // 4: illegal lengths and a start during FILL.
    repeat (2) @(posedge clk);
    in_prob = 0; out_prob = 100;
    e0 = err_seen;
    do_start(0);
    do_start(1025);
    do_start(6);
    do_start(3);
    repeat (3) @(posedge clk);
    #2;
    check("t4_err_count", err_seen - e0, 3);
    check("t4_busy", busy, 1);
    in_prob = 100;
    wait_done("t4_timeout", 200);
    check("t4_words", last_frame_outs, 6);

    // 5: asynchronous reset mid-drain, then a short frame.
    repeat (2) @(posedge clk);
    do_start(16);
    wait_outs("t5_reach", 5, 200);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_done", done, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    d0 = done_seen;
    do_start(2);
    wait_done("t5_timeout", 200);
    check("t5_words", last_frame_outs, 2);
    check("t5_done_count", done_seen - d0, 1);

    // 6: single-word frames back to back, second start right after done.
    repeat (2) @(posedge clk);
    d0 = done_seen;
    do_start(1);
    wait_done("t6_first", 100);
    do_start(1);
    wait_done("t6_second", 100);
    check("t6_words", last_frame_outs, 1);
    repeat (3) @(posedge clk);
    check("t6_done_count", done_seen - d0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
